quic_dec_word_fetch: RTL and testbench
======================================

QUIC_DEC_WORD_FETCH -- requirements
Module: quic_dec_word_fetch

Interface
REQ-001 SHALL have parameters, one per line: FIFO_DEPTH, 4, prefetch FIFO depth in 32-bit words (power of 2, >=2); TIMEOUT_CYCLES, 255, mem_ack watchdog limit (8-bit).
REQ-002 SHALL have ports: clk input 1, single clock; all logic on its rising edge.
REQ-003 reset_n input 1, reset, asynchronous, active-low.
REQ-004 quic_dec_state input 3, decoder state; `quic_dec_set` value from defines.v = load/clear.
REQ-005 start_addr input 32, byte address of first compressed word; bits [1:0] ignored.
REQ-006 word_count input 24, number of 32-bit words in the stream.
REQ-007 mem_req output 1, read request; mem_addr output 32, word-aligned read address.
REQ-008 mem_ack input 1, read done; mem_rdata input 32, read data valid with mem_ack.
REQ-009 next input 1, bitbuffer ready to accept a word.
REQ-010 bitstream_input output 32, FIFO head word; we output 1, head valid.
REQ-011 last_word output 1, final-word marker; done output 1, all words delivered; err output 1, fetch timeout.

Function
REQ-012 SHALL implement FSM IDLE, FETCH, WAIT, DRAIN, DONE.
REQ-013 While quic_dec_state == `quic_dec_set`: FSM to IDLE, FIFO flushed, addr_reg <= {start_addr[31:2],2'b00}, req_left <= word_count, out_left <= word_count, last_word/done/err cleared.
REQ-014 IDLE: first cycle with state != set: to FETCH if out_left != 0, else to DONE.
REQ-015 FETCH: if req_left != 0 and FIFO occupancy < FIFO_DEPTH, drive mem_req=1, mem_addr=addr_reg, to WAIT; if req_left == 0, to DRAIN.
REQ-016 WAIT: mem_req and mem_addr held stable until mem_ack; on mem_ack: mem_rdata pushed unmodified (no byte swap), addr_reg += 4, req_left -= 1, back to FETCH; mem_req low the cycle after mem_ack.
REQ-017 At most one outstanding request; mem_ack outside WAIT ignored.
REQ-018 FIFO first-word-fall-through: we = (occupancy != 0); bitstream_input = head; pop when we && next.
REQ-019 Push and pop in same cycle: occupancy unchanged; push into full FIFO impossible by REQ-015.
REQ-020 Latency: mem_ack at cycle N -> we high at N+1 with that word when FIFO was empty.
REQ-021 Pop decrements out_left; last_word = 1 for exactly the cycle in which we && next && out_left == 1, combinational with the pop.
REQ-022 DRAIN: to DONE when out_left == 0; DONE: done = 1, mem_req = 0, we = 0, held until next `quic_dec_set`.
REQ-023 word_count == 0: no mem_req, no we, no last_word; done one cycle after leaving set.
REQ-024 addr_reg wraps modulo 2^32 silently.
REQ-025 Entering `quic_dec_set` mid-WAIT abandons the request; a late mem_ack is ignored.

Reset
REQ-026 reset_n low: FSM IDLE, FIFO empty, addr_reg/req_left/out_left 0; mem_req, mem_addr, we, bitstream_input, last_word, done, err all 0.
REQ-027 Reset assertion mid-request drops mem_req the same instant, asynchronously.

Configuration
REQ-028 Macro QUIC_DEC_FETCH_TIMEOUT_EN defined: 8-bit counter cleared on WAIT entry, incremented per WAIT cycle; reaching TIMEOUT_CYCLES sets err=1, drops mem_req, FSM to DONE with done=0; err sticky until set or reset.
REQ-029 Macro not defined: no counter logic, err tied 0, WAIT lasts indefinitely.

Verification
REQ-030 word_count=3, start_addr=0x1000, mem_ack 1 cycle after each req, next=1 -> mem_addr 0x1000,0x1004,0x1008; 3 we pulses in order; last_word with 3rd; done.
REQ-031 word_count=8, next=0 -> exactly 4 requests, then mem_req low; next=1 -> remaining 4 fetched, 8 words delivered in order.
REQ-032 word_count=0 -> no mem_req, no we; done=1 one cycle after leaving set.
REQ-033 start_addr=0xFFFFFFFC, word_count=2 -> mem_addr 0xFFFFFFFC then 0x00000000.
REQ-034 `quic_dec_set` during WAIT, then mem_ack -> ack ignored, FIFO empty, new addr/count loaded.
REQ-035 QUIC_DEC_FETCH_TIMEOUT_EN on, mem_ack never -> err=1 after 255 WAIT cycles, mem_req=0, done=0; macro off -> mem_req stays high, err=0.

Source files
------------

// File: rtl/quic_dec_word_fetch.sv
// Compressed-stream word fetcher: reads word_count words from memory into a prefetch FIFO for the bitbuffer.
// Optional mem_ack watchdog enabled by defining QUIC_DEC_FETCH_TIMEOUT_EN.
`ifndef QUIC_DEC_SET
`define QUIC_DEC_SET 3'd0
`endif

module quic_dec_word_fetch #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  quic_dec_state,
  input  logic [31:0] start_addr,
  input  logic [23:0] word_count,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        next,
  output logic [31:0] bitstream_input,
  output logic        we,
  output logic        last_word,
  output logic        done,
  output logic        err
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("quic_dec_word_fetch: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   addr_reg;
  logic [23:0]   req_left;
  logic [23:0]   out_left;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          set_active;
  logic          push;
  logic          pop;
  logic          flush;
  logic          timeout_fire;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^start_addr[1:0];

  assign set_active = (quic_dec_state == `QUIC_DEC_SET);
  // Only an ack that lands while a request is outstanding carries data; late acks fall through here.
  assign push       = (state == S_WAIT) && mem_ack && !set_active;
  assign we         = (count != '0);
  assign pop        = we && next;
  assign flush      = set_active || timeout_fire;

  assign bitstream_input = we ? fifo_mem[rd_ptr] : '0;
  assign last_word       = pop && (out_left == 24'd1);

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      addr_reg <= '0;
      req_left <= '0;
      out_left <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      done     <= 1'b0;
    end else if (set_active) begin
      state    <= S_IDLE;
      addr_reg <= {start_addr[31:2], 2'b00};
      req_left <= word_count;
      out_left <= word_count;
      mem_req  <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (pop) out_left <= out_left - 24'd1;

      case (state)
        S_IDLE: begin
          if (out_left != '0) begin
            state <= S_FETCH;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_FETCH: begin
          if (req_left == '0) begin
            state <= S_DRAIN;
          end else if (count < FULL_CNT) begin
            mem_req  <= 1'b1;
            mem_addr <= addr_reg;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            addr_reg <= addr_reg + 32'd4;
            req_left <= req_left - 24'd1;
            state    <= S_FETCH;
          end else if (timeout_fire) begin
            mem_req <= 1'b0;
            state   <= S_DONE;
          end
        end

        S_DRAIN: begin
          if (out_left == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_DONE;
        end

        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef QUIC_DEC_FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       err_q;

  assign timeout_fire = (state == S_WAIT) && !mem_ack && !set_active && (tmo_cnt == TMO_LAST);
  assign err          = err_q;

  // WAIT is only ever entered from FETCH, so clearing in FETCH gives a zero count on WAIT entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if (set_active) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_FETCH)     tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 8'd1;
      if (timeout_fire) err_q <= 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_quic_dec_word_fetch.sv
// Self-checking bench for quic_dec_word_fetch: randomized memory latency and consumer back-pressure
// checked against a queue-based model of the fetched word stream.
`timescale 1ns/1ps
`ifndef QUIC_DEC_SET
`define QUIC_DEC_SET 3'd0
`endif

module tb_quic_dec_word_fetch;

  localparam int         DEPTH = 4;
  localparam logic [2:0] SET   = `QUIC_DEC_SET;
  localparam logic [2:0] RUN   = SET + 3'd2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  quic_dec_state;
  logic [31:0] start_addr;
  logic [23:0] word_count;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        next;
  logic [31:0] bitstream_input;
  logic        we;
  logic        last_word;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  quic_dec_word_fetch #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .quic_dec_state  (quic_dec_state),
    .start_addr      (start_addr),
    .word_count      (word_count),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .next            (next),
    .bitstream_input (bitstream_input),
    .we              (we),
    .last_word       (last_word),
    .done            (done),
    .err             (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the words the memory has delivered but the consumer has not yet taken.
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  int          acked, popped, wc_cur;

  logic [2:0]  state_drv;
  bit          mon_en, resp_en, force_ack;
  int          next_pct, hold_left, delay_max, wait_cnt, wait_tgt;
  bit          req_prev, ack_prev;
  logic [31:0] addr_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1ns later, then update the model.
  task automatic cycle();
    bit legit;
    bit exp_we;
    bit exp_last;
    @(negedge clk);
    legit = 1'b0;
    if (resp_en && mem_req === 1'b1 && !ack_prev) begin
      if (wait_cnt >= wait_tgt) legit = 1'b1;
      else wait_cnt++;
    end
    quic_dec_state = state_drv;
    mem_ack        = legit || force_ack;
    mem_rdata      = $urandom;
    force_ack      = 1'b0;
    if (hold_left > 0) begin
      next = 1'b0;
      hold_left--;
    end else begin
      next = ($urandom_range(99) < next_pct);
    end
    #1;
    if (mon_en) begin
      exp_we = (exp_q.size() != 0);
      check("we", we, exp_we);
      if (exp_we) check("bitstream_input", bitstream_input, exp_q[0]);
      exp_last = exp_we && next && (popped == wc_cur - 1);
      check("last_word", last_word, exp_last);
      check("err", err, 0);
      if (ack_prev) begin
        check("mem_req_after_ack", mem_req, 0);
      end else if (req_prev) begin
        check("mem_req_held", mem_req, 1);
        check("mem_addr_held", mem_addr, addr_prev);
      end
      if (legit) check("mem_addr", mem_addr, exp_addr);
      if (done === 1'b1) check("done_early", popped, wc_cur);
      if (exp_we && next) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (legit) begin
        exp_q.push_back(mem_rdata);
        acked++;
        exp_addr += 32'd4;
        wait_cnt = 0;
        wait_tgt = $urandom_range(delay_max);
      end
    end
    req_prev  = (mem_req === 1'b1) && !legit;
    addr_prev = mem_addr;
    ack_prev  = legit;
  endtask

  task automatic apply_set(input logic [31:0] base, input int wc, input bit late_ack);
    mon_en     = 1'b0;
    resp_en    = 1'b0;
    next_pct   = 0;
    hold_left  = 0;
    state_drv  = SET;
    start_addr = base;
    word_count = 24'(wc);
    cycle();
    cycle();
    check("set_mem_req", mem_req, 0);
    check("set_we", we, 0);
    check("set_done", done, 0);
    exp_q.delete();
    exp_addr  = {base[31:2], 2'b00};
    acked     = 0;
    popped    = 0;
    wc_cur    = wc;
    req_prev  = 1'b0;
    ack_prev  = 1'b0;
    wait_cnt  = 0;
    wait_tgt  = 0;
    force_ack = late_ack;
  endtask

  task automatic run_stream(input logic [31:0] base, input int wc, input int dmax,
                            input int npct, input int hold, input bit late_ack);
    int n;
    apply_set(base, wc, late_ack);
    delay_max = dmax;
    next_pct  = npct;
    hold_left = hold;
    resp_en   = 1'b1;
    mon_en    = 1'b1;
    state_drv = RUN;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      cycle();
      n++;
      if (hold > 0 && n == hold) begin
        check("hold_requests", acked, DEPTH);
        check("hold_mem_req", mem_req, 0);
      end
    end
    check("done", done, 1);
    check("words_out", popped, wc);
    check("words_req", acked, wc);
    check("end_we", we, 0);
    check("end_mem_req", mem_req, 0);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    check(tag, mem_req, 1);
  endtask

  initial begin
    int hi;
    int n;
    reset_n        = 1'b0;
    quic_dec_state = SET;
    start_addr     = '0;
    word_count     = '0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    next           = 1'b0;
    state_drv      = SET;
    force_ack      = 1'b0;
    mon_en         = 1'b0;
    resp_en        = 1'b0;
    req_prev       = 1'b0;
    ack_prev       = 1'b0;
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_we", we, 0);
    check("rst_bitstream_input", bitstream_input, 0);
    check("rst_last_word", last_word, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Three words, immediate ack, consumer always ready.
    run_stream(32'h0000_1000, 3, 0, 100, 0, 1'b0);

    // Consumer stalled: prefetch must stop at FIFO depth; low address bits are ignored.
    run_stream(32'h0000_2003, 8, 0, 100, 40, 1'b0);

    // Empty stream: done one cycle after leaving set, no traffic.
    apply_set(32'h0000_3000, 0, 1'b0);
    state_drv = RUN;
    mon_en    = 1'b1;
    resp_en   = 1'b1;
    cycle();
    check("wc0_done_first", done, 0);
    check("wc0_mem_req_first", mem_req, 0);
    cycle();
    check("wc0_done", done, 1);
    check("wc0_mem_req", mem_req, 0);
    check("wc0_we", we, 0);

    // Address wrap at the top of the address space.
    run_stream(32'hFFFF_FFFC, 2, 0, 100, 0, 1'b0);

    // Randomized lengths, latencies and back-pressure.
    for (int i = 0; i < 6; i++) begin
      run_stream($urandom, $urandom_range(1, 20), $urandom_range(0, 3),
                 $urandom_range(20, 100), 0, 1'b0);
    end

    // Set while a request is outstanding, then a stale ack arrives.
    apply_set(32'h0000_4000, 5, 1'b0);
    state_drv = RUN;
    mon_en    = 1'b1;
    wait_req("abandon_req_seen");
    run_stream(32'h0000_5004, 6, 2, 70, 0, 1'b1);

    // Asynchronous reset in the middle of a request.
    apply_set(32'h0000_6000, 3, 1'b0);
    state_drv = RUN;
    mon_en    = 1'b1;
    wait_req("rst_req_seen");
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_we", we, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Memory never answers.
    apply_set(32'h0000_7000, 2, 1'b0);
    state_drv = RUN;
`ifdef QUIC_DEC_FETCH_TIMEOUT_EN
    n  = 0;
    hi = 0;
    while (err !== 1'b1 && n < 400) begin
      cycle();
      n++;
      if (mem_req === 1'b1) hi++;
    end
    check("tmo_err", err, 1);
    check("tmo_req_cycles", hi, 255);
    check("tmo_mem_req", mem_req, 0);
    check("tmo_done", done, 0);
    repeat (3) cycle();
    check("tmo_err_sticky", err, 1);
`else
    n  = 0;
    hi = 0;
    while (n < 300) begin
      cycle();
      n++;
      if (mem_req === 1'b1) hi++;
    end
    check("no_tmo_mem_req", mem_req, 1);
    check("no_tmo_req_cycles", hi, 298);
    check("no_tmo_err", err, 0);
    check("no_tmo_done", done, 0);
`endif

    // Recovery after the stalled request.
    run_stream(32'h0000_8000, 12, 3, 60, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
